// File: rtl/croc_pkg.sv
// Shared SoC constants, OBI manager types and the block-swapper FSM encoding.
package croc_pkg;

  localparam int unsigned NUM_REQ_BLOCKS         = 2;
  localparam int unsigned NUM_SRAM_ADDRESSES     = 12;
  localparam logic [31:0] FIRST_USABLE_SRAM_ADDR = 32'h1000_0800;

  localparam int unsigned BlkIdxWidth = 8;

  typedef enum logic [2:0] {
    SWP_IDLE,
    SWP_RD_A,
    SWP_RD_B,
    SWP_WR_A,
    SWP_WR_B,
    SWP_FINISH
  } swap_state_e;

  typedef enum logic {
    PH_ADDR,
    PH_RESP
  } swap_phase_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        a_optional;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    mgr_obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
    logic        r_optional;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

  // Byte address of word k inside block blk, wrapping in 32 bits.
  function automatic logic [31:0] blk_word_addr(input logic [31:0]            base,
                                                input logic [BlkIdxWidth-1:0] blk,
                                                input int unsigned            words,
                                                input logic [31:0]            k);
    return base + (32'(blk) * (words * 32'd4)) + (k << 2);
  endfunction

endpackage

// File: rtl/swap_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the first request at or after the pointer.
module swap_rr_arbiter #(
  parameter int unsigned NumReq = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      for (int unsigned j = 0; j < NumReq; j++) begin
        if (!found && req_i[j] && (j == (32'(ptr_q) + off) % NumReq)) begin
          found    = 1'b1;
          gnt_o[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      for (int unsigned j = 0; j < NumReq; j++) begin
        if (gnt_o[j]) begin
          ptr_d = (j == NumReq - 1) ? '0 : PtrW'(j + 1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_block_swapper.sv
// Exchanges the contents of two SRAM blocks word by word over one OBI manager port.
module sram_block_swapper
  import croc_pkg::*;
#(
  parameter int unsigned NumReq     = NUM_REQ_BLOCKS,
  parameter int unsigned BlockWords = NUM_SRAM_ADDRESSES,
  parameter logic [31:0] BaseAddr   = FIRST_USABLE_SRAM_ADDR
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][BlkIdxWidth-1:0]  req_blk_a_i,
  input  logic [NumReq-1:0][BlkIdxWidth-1:0]  req_blk_b_i,
  output logic [NumReq-1:0]                   done_o,
  output logic [NumReq-1:0]                   err_o,
  output logic                                busy_o,
  output mgr_obi_req_t                        obi_req_o,
  input  mgr_obi_rsp_t                        obi_rsp_i
);

  localparam int unsigned CntW = (BlockWords > 1) ? $clog2(BlockWords) : 1;
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  swap_state_e            state_q, state_d;
  swap_phase_e            phase_q, phase_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BlkIdxWidth-1:0] blk_a_q, blk_a_d, blk_b_q, blk_b_d;
  logic [31:0]            reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic                   err_q, err_d;

  logic                   idle, arb_en;
  logic [NumReq-1:0]      gnt;
  logic [BlkIdxWidth-1:0] sel_a, sel_b;
  logic [IdxW-1:0]        sel_idx;
  logic                   bus_state;
  logic                   unused_rsp;

  assign unused_rsp = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

  assign idle   = (state_q == SWP_IDLE);
  assign arb_en = idle && !rst_i && (|req_valid_i);

  swap_rr_arbiter #(
    .NumReq(NumReq)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_valid_i),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign req_ready_o = (idle && !rst_i) ? gnt : '0;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_idx = '0;
    for (int unsigned j = 0; j < NumReq; j++) begin
      if (gnt[j]) begin
        sel_a   = req_blk_a_i[j];
        sel_b   = req_blk_b_i[j];
        sel_idx = IdxW'(j);
      end
    end
  end

  assign bus_state = (state_q == SWP_RD_A) || (state_q == SWP_RD_B) ||
                     (state_q == SWP_WR_A) || (state_q == SWP_WR_B);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    blk_a_d = blk_a_q;
    blk_b_d = blk_b_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    owner_d = owner_q;
    err_d   = err_q;
    unique case (state_q)
      SWP_IDLE: begin
        if (arb_en) begin
          blk_a_d = sel_a;
          blk_b_d = sel_b;
          owner_d = sel_idx;
          cnt_d   = '0;
          err_d   = 1'b0;
          phase_d = PH_ADDR;
          state_d = (sel_a == sel_b) ? SWP_FINISH : SWP_RD_A;
        end
      end
      SWP_RD_A, SWP_RD_B, SWP_WR_A, SWP_WR_B: begin
        if (phase_q == PH_ADDR) begin
          if (obi_rsp_i.gnt) phase_d = PH_RESP;
        end else if (obi_rsp_i.rvalid) begin
          // Next request starts a cycle after rvalid, keeping one access in flight.
          phase_d = PH_ADDR;
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = SWP_FINISH;
          end else begin
            unique case (state_q)
              SWP_RD_A: begin
                reg_a_d = obi_rsp_i.r.rdata;
                state_d = SWP_RD_B;
              end
              SWP_RD_B: begin
                reg_b_d = obi_rsp_i.r.rdata;
                state_d = SWP_WR_A;
              end
              SWP_WR_A: state_d = SWP_WR_B;
              default: begin
                if (cnt_q == CntW'(BlockWords - 1)) begin
                  state_d = SWP_FINISH;
                end else begin
                  cnt_d   = cnt_q + CntW'(1);
                  state_d = SWP_RD_A;
                end
              end
            endcase
          end
        end
      end
      SWP_FINISH: state_d = SWP_IDLE;
      default:    state_d = SWP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SWP_IDLE;
      phase_q <= PH_ADDR;
      cnt_q   <= '0;
      blk_a_q <= '0;
      blk_b_q <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      blk_a_q <= blk_a_d;
      blk_b_q <= blk_b_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    obi_req_o = '0;
    if (bus_state) begin
      obi_req_o.req    = (phase_q == PH_ADDR);
      obi_req_o.a.addr = blk_word_addr(BaseAddr,
                                       ((state_q == SWP_RD_A) || (state_q == SWP_WR_A)) ?
                                       blk_a_q : blk_b_q,
                                       BlockWords, 32'(cnt_q));
      obi_req_o.a.we   = (state_q == SWP_WR_A) || (state_q == SWP_WR_B);
      obi_req_o.a.be   = 4'hF;
      obi_req_o.a.wdata = (state_q == SWP_WR_A) ? reg_b_q :
                          (state_q == SWP_WR_B) ? reg_a_q : '0;
    end
  end

  always_comb begin
    done_o = '0;
    err_o  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      done_o[i] = (state_q == SWP_FINISH) && (owner_q == IdxW'(i));
      err_o[i]  = (state_q == SWP_FINISH) && (owner_q == IdxW'(i)) && err_q;
    end
  end

  assign busy_o = !idle;

endmodule

// File: tb/tb_sram_block_swapper.sv
// Self-checking bench: OBI memory slave plus a word-array reference of block swaps.
module tb_sram_block_swapper;
  import croc_pkg::*;

  localparam int unsigned BW   = 12;
  localparam logic [31:0] BASE = 32'h1000_0800;
  localparam int unsigned MEMW = 256;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         req_valid = '0;
  logic [1:0]         req_ready;
  logic [1:0][7:0]    blk_a = '0;
  logic [1:0][7:0]    blk_b = '0;
  logic [1:0]         done;
  logic [1:0]         err;
  logic               busy;
  mgr_obi_req_t       obi_req;
  mgr_obi_rsp_t       obi_rsp;

  always #5 clk = ~clk;

  sram_block_swapper #(
    .NumReq    (2),
    .BlockWords(BW),
    .BaseAddr  (BASE)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_blk_a_i (blk_a),
    .req_blk_b_i (blk_b),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy),
    .obi_req_o   (obi_req),
    .obi_rsp_i   (obi_rsp)
  );

  int tests = 0;
  int fails = 0;

  // Slave state: written only by the slave process.
  logic [31:0] mem [MEMW];
  int unsigned req_cycles = 0;
  int unsigned accesses   = 0;
  int unsigned viol       = 0;
  // Slave configuration: written only by the test sequence.
  int unsigned gnt_delay = 0;
  bit          err_en    = 1'b0;
  logic [31:0] err_addr  = '0;

  logic [31:0] ref_mem [MEMW];

  initial begin : slave
    mgr_obi_rsp_t rsp;
    bit           pend, pend_err, held;
    logic [31:0]  pend_data, h_addr, h_wdata;
    logic         h_we;
    int unsigned  waitc, idx;
    for (int i = 0; i < MEMW; i++) mem[i] = $urandom;
    obi_rsp = '0;
    pend = 0; pend_err = 0; held = 0; waitc = 0;
    pend_data = '0; h_addr = '0; h_wdata = '0; h_we = 1'b0;
    forever begin
      @(negedge clk);
      rsp = '0;
      if (rst) begin
        pend = 0; held = 0; waitc = 0;
      end else begin
        if (pend) begin
          rsp.rvalid  = 1'b1;
          rsp.r.rdata = pend_data;
          rsp.r.err   = pend_err;
          pend        = 0;
        end
        if (obi_req.req) begin
          req_cycles++;
          if (rsp.rvalid) viol++;
          if (obi_req.a.be != 4'hF || obi_req.a.aid || obi_req.a.a_optional ||
              (!obi_req.a.we && obi_req.a.wdata != 32'd0)) viol++;
          if (held && (obi_req.a.addr != h_addr || obi_req.a.we != h_we ||
                       obi_req.a.wdata != h_wdata)) viol++;
          if (waitc >= gnt_delay) begin
            rsp.gnt   = 1'b1;
            waitc     = 0;
            held      = 0;
            accesses++;
            pend      = 1;
            pend_err  = 0;
            pend_data = '0;
            idx = (obi_req.a.addr - BASE) >> 2;
            if (obi_req.a.addr < BASE || idx >= MEMW || obi_req.a.addr[1:0] != 2'b00) begin
              viol++;
            end else if (obi_req.a.we) begin
              mem[idx] = obi_req.a.wdata;
            end else begin
              pend_data = mem[idx];
              pend_err  = err_en && (obi_req.a.addr == err_addr);
            end
          end else begin
            waitc++;
            held    = 1;
            h_addr  = obi_req.a.addr;
            h_we    = obi_req.a.we;
            h_wdata = obi_req.a.wdata;
          end
        end else begin
          held = 0;
        end
      end
      obi_rsp = rsp;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  task automatic model_swap(input int a, input int b, input int nwords);
    logic [31:0] t;
    if (a == b) return;
    for (int k = 0; k < nwords; k++) begin
      t = ref_mem[a * BW + k];
      ref_mem[a * BW + k] = ref_mem[b * BW + k];
      ref_mem[b * BW + k] = t;
    end
  endtask

  function automatic int mem_mismatches();
    int n = 0;
    for (int i = 0; i < MEMW; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Drives one request to completion; lat is cycles from accept edge to done (-1 on timeout).
  task automatic run_swap(input int r, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [1:0] dv, output logic [1:0] ev);
    bit got = 0;
    lat = -1; dv = '0; ev = '0;
    @(posedge clk); #1;
    req_valid[r] = 1'b1; blk_a[r] = a; blk_b[r] = b;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1;
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    if (!got) return;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        lat = n; dv = done; ev = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (obi_req !== '0) begin fails++; $display("FAIL reset_obi_req: got %h want 0", obi_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 2'b00) begin fails++; $display("FAIL reset_done: got %b want 00", done); end
    tests++; if (err !== 2'b00) begin fails++; $display("FAIL reset_err: got %b want 00", err); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < MEMW; i++) ref_mem[i] = mem[i];
  endtask

  task automatic test_single_swap();
    int lat, mm; logic [1:0] dv, ev;
    int unsigned acc0 = accesses, v0 = viol;
    gnt_delay = 0;
    run_swap(0, 8'd1, 8'd2, lat, dv, ev);
    model_swap(1, 2, BW);
    mm = mem_mismatches();
    tests++; if (lat !== 97) begin fails++; $display("FAIL single_latency: got %0d want 97", lat); end
    tests++; if (dv !== 2'b01) begin fails++; $display("FAIL single_done: got %b want 01", dv); end
    tests++; if (ev !== 2'b00) begin fails++; $display("FAIL single_err: got %b want 00", ev); end
    tests++; if (mm !== 0) begin fails++; $display("FAIL single_mem: %0d words differ, want 0", mm); end
    tests++; if (accesses - acc0 !== 48) begin fails++; $display("FAIL single_accesses: got %0d want 48", accesses - acc0); end
    tests++; if (viol !== v0) begin fails++; $display("FAIL single_protocol: got %0d violations want 0", viol - v0); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_gnt_delay();
    int lat, mm; logic [1:0] dv, ev;
    int unsigned v0 = viol;
    gnt_delay = 3;
    run_swap(0, 8'd1, 8'd2, lat, dv, ev);
    gnt_delay = 0;
    model_swap(1, 2, BW);
    mm = mem_mismatches();
    tests++; if (lat !== 48 * 5 + 1) begin fails++; $display("FAIL delay_latency: got %0d want %0d", lat, 48 * 5 + 1); end
    tests++; if (viol !== v0) begin fails++; $display("FAIL delay_stability: got %0d violations want 0", viol - v0); end
    tests++; if (mm !== 0) begin fails++; $display("FAIL delay_mem: %0d words differ, want 0", mm); end
    tests++; if (ev !== 2'b00) begin fails++; $display("FAIL delay_err: got %b want 00", ev); end
  endtask

  task automatic test_same_block();
    int lat; logic [1:0] dv, ev;
    int unsigned rc0 = req_cycles;
    run_swap(1, 8'd5, 8'd5, lat, dv, ev);
    tests++; if (lat !== 1) begin fails++; $display("FAIL same_latency: got %0d want 1", lat); end
    tests++; if (dv !== 2'b10) begin fails++; $display("FAIL same_done: got %b want 10", dv); end
    tests++; if (ev !== 2'b00) begin fails++; $display("FAIL same_err: got %b want 00", ev); end
    tests++; if (req_cycles - rc0 !== 0) begin fails++; $display("FAIL same_req_cycles: got %0d want 0", req_cycles - rc0); end
  endtask

  task automatic test_bus_error();
    int lat, mm; logic [1:0] dv, ev;
    int unsigned acc0 = accesses, rc0 = req_cycles;
    err_addr = BASE + 32'(2 * BW * 4) + 32'd12;
    err_en   = 1'b1;
    run_swap(0, 8'd1, 8'd2, lat, dv, ev);
    err_en   = 1'b0;
    model_swap(1, 2, 3);
    mm = mem_mismatches();
    repeat (5) @(negedge clk);
    tests++; if (lat !== 29) begin fails++; $display("FAIL err_latency: got %0d want 29", lat); end
    tests++; if (dv !== 2'b01) begin fails++; $display("FAIL err_done: got %b want 01", dv); end
    tests++; if (ev !== 2'b01) begin fails++; $display("FAIL err_flag: got %b want 01", ev); end
    tests++; if (accesses - acc0 !== 14) begin fails++; $display("FAIL err_accesses: got %0d want 14", accesses - acc0); end
    tests++; if (req_cycles - rc0 !== 14) begin fails++; $display("FAIL err_req_cycles: got %0d want 14", req_cycles - rc0); end
    tests++; if (mm !== 0) begin fails++; $display("FAIL err_mem: %0d words differ, want 0", mm); end
  endtask

  task automatic wait_done(output logic [1:0] dv);
    dv = '0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done != 2'b00) begin dv = done; break; end
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] dv;
    int mm;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req_valid = 2'b11;
    blk_a[0] = 8'd3; blk_b[0] = 8'd4;
    blk_a[1] = 8'd6; blk_b[1] = 8'd7;
    @(negedge clk);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL arb_first: got %b want 01", req_ready); end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_done(dv);
    tests++; if (dv !== 2'b01) begin fails++; $display("FAIL arb_done0: got %b want 01", dv); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL arb_ready_finish: got %b want 00", req_ready); end
    model_swap(3, 4, BW);
    @(negedge clk);
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL arb_second: got %b want 10", req_ready); end
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_done(dv);
    tests++; if (dv !== 2'b10) begin fails++; $display("FAIL arb_done1: got %b want 10", dv); end
    model_swap(6, 7, BW);
    @(posedge clk); #1;
    req_valid = 2'b11;
    blk_a[0] = 8'd8;  blk_b[0] = 8'd9;
    blk_a[1] = 8'd10; blk_b[1] = 8'd10;
    @(negedge clk);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL arb_rr_order: got %b want 01", req_ready); end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_done(dv);
    model_swap(8, 9, BW);
    @(negedge clk);
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL arb_rr_second: got %b want 10", req_ready); end
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_done(dv);
    tests++; if (dv !== 2'b10) begin fails++; $display("FAIL arb_done_same: got %b want 10", dv); end
    mm = mem_mismatches();
    tests++; if (mm !== 0) begin fails++; $display("FAIL arb_mem: %0d words differ, want 0", mm); end
  endtask

  task automatic test_reset_mid();
    int lat, mm, pulses = 0; logic [1:0] dv, ev;
    bit got = 0, found = 0;
    logic [31:0] seen_addr = '0;
    gnt_delay = 10;
    @(posedge clk); #1;
    req_valid[0] = 1'b1; blk_a[0] = 8'd1; blk_b[0] = 8'd3;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (obi_req.req && obi_req.a.we) begin found = 1; seen_addr = obi_req.a.addr; end
    end
    tests++; if (seen_addr !== BASE + 32'(BW * 4)) begin fails++; $display("FAIL midrst_wr_a_addr: got %h want %h", seen_addr, BASE + 32'(BW * 4)); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (obi_req !== '0) begin fails++; $display("FAIL midrst_obi_req: got %h want 0", obi_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(posedge clk); #1 rst = 1'b0;
    gnt_delay = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done != 2'b00) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses want 0", pulses); end
    mm = mem_mismatches();
    tests++; if (mm !== 0) begin fails++; $display("FAIL midrst_mem_untouched: %0d words differ, want 0", mm); end
    run_swap(0, 8'd1, 8'd3, lat, dv, ev);
    model_swap(1, 3, BW);
    mm = mem_mismatches();
    tests++; if (lat !== 97) begin fails++; $display("FAIL midrst_fresh_latency: got %0d want 97", lat); end
    tests++; if (mm !== 0) begin fails++; $display("FAIL midrst_fresh_mem: %0d words differ, want 0", mm); end
  endtask

  task automatic test_random();
    int lat, mm, r, a, b, d, exp_lat; logic [1:0] dv, ev;
    for (int it = 0; it < 8; it++) begin
      r = int'($urandom_range(0, 1));
      a = int'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 2));
      gnt_delay = d;
      exp_lat = (a == b) ? 1 : 4 * BW * (2 + d) + 1;
      run_swap(r, 8'(a), 8'(b), lat, dv, ev);
      model_swap(a, b, BW);
      mm = mem_mismatches();
      tests++; if (lat !== exp_lat) begin fails++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, exp_lat); end
      tests++; if (dv !== 2'(1 << r)) begin fails++; $display("FAIL rand_done[%0d]: got %b want %b", it, dv, 2'(1 << r)); end
      tests++; if (ev !== 2'b00) begin fails++; $display("FAIL rand_err[%0d]: got %b want 00", it, ev); end
      tests++; if (mm !== 0) begin fails++; $display("FAIL rand_mem[%0d]: %0d words differ, want 0", it, mm); end
    end
    gnt_delay = 0;
  endtask

  initial begin : main
    test_reset();
    test_single_swap();
    test_gnt_delay();
    test_same_block();
    test_bus_error();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
